// File: rtl/traffic_ctrl_multi.sv
// Round-robin traffic-light controller for N_DIR approaches with
// all-red clearance, latched pedestrian WALK and optional vehicle sensing.
module traffic_ctrl_multi #(
  parameter int N_DIR      = 2,
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int WALK_CYC   = 6,
  parameter int SKIP_IDLE  = 0,
  parameter int CNT_W      = 8,
  localparam int DIR_W =
    ($clog2(N_DIR) > 1) ? $clog2(N_DIR) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_DIR-1:0]   veh_req,
  input  logic               ped_req,
  output logic [3*N_DIR-1:0] light,
  output logic [1:0]         state,
  output logic [DIR_W-1:0]   active_dir,
  output logic               walk,
  output logic               ped_pending
);

  typedef enum logic [1:0] {
    S_GREEN  = 2'b00,
    S_YELLOW = 2'b01,
    S_ALLRED = 2'b10,
    S_WALK   = 2'b11
  } st_t;

  localparam logic [CNT_W-1:0] T_G = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] T_Y = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] T_A = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] T_W = CNT_W'(WALK_CYC - 1);

  st_t                st_q, st_n;
  logic [DIR_W-1:0]   dir_q, dir_n;
  logic [CNT_W-1:0]   tmr_q, tmr_n;
  logic               ped_q, ped_n;
  logic               walk_q;
  logic [3*N_DIR-1:0] light_q, light_n;

  logic               expire;
  logic               other_req;
  logic               found;
  logic [DIR_W-1:0]   sel;
  logic [DIR_W-1:0]   nxt_dir;

  assign expire = (tmr_q == '0);
  assign nxt_dir = (dir_q == DIR_W'(N_DIR - 1)) ?
                   '0 : dir_q + 1'b1;

  // Descending distance so the nearest requester after dir_q wins.
  always_comb begin
    found     = 1'b0;
    sel       = dir_q;
    other_req = 1'b0;
    for (int k = N_DIR; k >= 1; k--) begin
      for (int d = 0; d < N_DIR; d++) begin
        if (veh_req[d] &&
            d == (int'(dir_q) + k) % N_DIR) begin
          found = 1'b1;
          sel   = DIR_W'(d);
        end
      end
    end
    for (int d = 0; d < N_DIR; d++) begin
      if (veh_req[d] && d != int'(dir_q))
        other_req = 1'b1;
    end
  end

  always_comb begin
    logic ped_clr;
    st_n    = st_q;
    dir_n   = dir_q;
    tmr_n   = tmr_q - 1'b1;
    ped_clr = 1'b0;
    unique case (st_q)
      S_GREEN: begin
        if (expire) begin
          if (SKIP_IDLE != 0 && !other_req && !ped_q) begin
            tmr_n = T_G;
          end else begin
            st_n  = S_YELLOW;
            tmr_n = T_Y;
          end
        end
      end
      S_YELLOW: begin
        if (expire) begin
          st_n  = S_ALLRED;
          tmr_n = T_A;
        end
      end
      S_ALLRED: begin
        if (expire) begin
          if (ped_q) begin
            st_n    = S_WALK;
            tmr_n   = T_W;
            ped_clr = 1'b1;
          end else if (SKIP_IDLE == 0) begin
            st_n  = S_GREEN;
            dir_n = nxt_dir;
            tmr_n = T_G;
          end else if (found) begin
            st_n  = S_GREEN;
            dir_n = sel;
            tmr_n = T_G;
          end else begin
            tmr_n = T_A;
          end
        end
      end
      S_WALK: begin
        if (expire) begin
          st_n  = S_ALLRED;
          tmr_n = T_A;
        end
      end
      default: ;
    endcase
    ped_n = ped_q;
    if (ped_clr)
      ped_n = 1'b0;
    else if (ped_req && st_q != S_WALK)
      ped_n = 1'b1;
  end

  always_comb begin
    for (int d = 0; d < N_DIR; d++) begin
      light_n[3*d +: 3] = 3'b100;
      if (int'(dir_n) == d) begin
        if (st_n == S_GREEN)
          light_n[3*d +: 3] = 3'b001;
        else if (st_n == S_YELLOW)
          light_n[3*d +: 3] = 3'b010;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= S_ALLRED;
      dir_q   <= DIR_W'(N_DIR - 1);
      tmr_q   <= T_A;
      ped_q   <= 1'b0;
      walk_q  <= 1'b0;
      light_q <= {N_DIR{3'b100}};
    end else begin
      st_q    <= st_n;
      dir_q   <= dir_n;
      tmr_q   <= tmr_n;
      ped_q   <= ped_n;
      walk_q  <= (st_n == S_WALK);
      light_q <= light_n;
    end
  end

  assign light       = light_q;
  assign state       = st_q;
  assign active_dir  = dir_q;
  assign walk        = walk_q;
  assign ped_pending = ped_q;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Directed bench for traffic_ctrl_multi: fixed rotation with pedestrians
// on a 3-way instance, vehicle sensing on a 4-way instance.
module tb_traffic_ctrl_multi;

  logic        clk = 1'b0;
  logic        rst0, rst1;
  logic [2:0]  veh0;
  logic [3:0]  veh1;
  logic        ped0, ped1;
  logic [8:0]  l0;
  logic [11:0] l1;
  logic [1:0]  s0, s1;
  logic [1:0]  d0, d1;
  logic        w0, w1, p0, p1;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  logic [11:0] pl0 = '0;
  logic [11:0] pl1 = '0;

  localparam logic [8:0]  L0_R  = 9'b100_100_100;
  localparam logic [8:0]  L0_G0 = 9'b100_100_001;
  localparam logic [8:0]  L0_Y0 = 9'b100_100_010;
  localparam logic [8:0]  L0_G1 = 9'b100_001_100;
  localparam logic [8:0]  L0_G2 = 9'b001_100_100;
  localparam logic [11:0] L1_R  = 12'b100_100_100_100;
  localparam logic [11:0] L1_G2 = 12'b100_001_100_100;

  traffic_ctrl_multi #(.N_DIR(3)) u0 (
    .clk(clk), .rst(rst0), .veh_req(veh0), .ped_req(ped0),
    .light(l0), .state(s0), .active_dir(d0),
    .walk(w0), .ped_pending(p0)
  );

  traffic_ctrl_multi #(.N_DIR(4), .SKIP_IDLE(1)) u1 (
    .clk(clk), .rst(rst1), .veh_req(veh1), .ped_req(ped1),
    .light(l1), .state(s1), .active_dir(d1),
    .walk(w1), .ped_pending(p1)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h",
                tag, obs, exp);
  endtask

  function automatic bit inv_ok(logic [11:0] l,
                                logic [11:0] pl, int n,
                                logic w, bit trans);
    int nr;
    bit ok;
    nr = 0;
    ok = 1'b1;
    for (int d = 0; d < n; d++) begin
      if (l[3*d +: 3] != 3'b100) nr++;
      if (trans && pl[3*d +: 3] == 3'b001 &&
          l[3*d +: 3] == 3'b100) ok = 1'b0;
      if (trans && pl[3*d +: 3] == 3'b100 &&
          l[3*d +: 3] == 3'b010) ok = 1'b0;
    end
    if (nr > 1) ok = 1'b0;
    if (w && nr != 0) ok = 1'b0;
    return ok;
  endfunction

  task automatic tick();
    bit r0, r1;
    r0 = rst0;
    r1 = rst1;
    @(posedge clk);
    #1;
    cyc++;
    chk("inv0", 32'(inv_ok({3'b0, l0}, pl0, 3, w0, !r0)), 1);
    chk("inv1", 32'(inv_ok(l1, pl1, 4, w1, !r1)), 1);
    pl0 = {3'b0, l0};
    pl1 = l1;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int  n;
    bit  saw, bad;
    rst0 = 1'b1; rst1 = 1'b1;
    veh0 = '0;   veh1 = '0;
    ped0 = 1'b0; ped1 = 1'b0;
    run(2);
    rst0 = 1'b0;
    cyc  = 0;
    chk("rst_state", 32'(s0), 2);
    chk("rst_dir", 32'(d0), 2);
    chk("rst_light", 32'(l0), 32'(L0_R));
    chk("rst_walk", 32'(w0), 0);
    chk("rst_ped", 32'(p0), 0);
    run(1);
    chk("c1_allred", 32'(s0), 2);
    run(1);
    chk("c2_green", 32'(s0), 0);
    chk("c2_dir", 32'(d0), 0);
    chk("c2_light", 32'(l0), 32'(L0_G0));
    run(7);
    chk("c9_green", 32'(s0), 0);
    run(1);
    chk("c10_yel", 32'(s0), 1);
    chk("c10_light", 32'(l0), 32'(L0_Y0));
    run(2);
    chk("c12_yel", 32'(s0), 1);
    run(1);
    chk("c13_allred", 32'(s0), 2);
    chk("c13_light", 32'(l0), 32'(L0_R));
    run(2);
    chk("c15_green", 32'(s0), 0);
    chk("c15_dir", 32'(d0), 1);
    chk("c15_light", 32'(l0), 32'(L0_G1));
    run(13);
    chk("c28_dir", 32'(d0), 2);
    chk("c28_light", 32'(l0), 32'(L0_G2));
    run(12);
    chk("c40_allred", 32'(s0), 2);
    run(1);
    chk("c41_green", 32'(s0), 0);
    chk("c41_wrap", 32'(d0), 0);

    ped0 = 1'b1;
    run(1);
    ped0 = 1'b0;
    chk("ped_latch", 32'(p0), 1);
    run(12);
    chk("walk_state", 32'(s0), 3);
    chk("walk_lamp", 32'(w0), 1);
    chk("walk_light", 32'(l0), 32'(L0_R));
    chk("walk_ped", 32'(p0), 0);
    run(5);
    chk("walk_last", 32'(s0), 3);
    run(1);
    chk("post_walk", 32'(s0), 2);
    chk("post_walk_w", 32'(w0), 0);
    run(2);
    chk("resume_st", 32'(s0), 0);
    chk("resume_dir", 32'(d0), 1);

    ped0 = 1'b1;
    run(13);
    chk("hold_walk", 32'(s0), 3);
    chk("clr_wins", 32'(p0), 0);
    run(5);
    chk("hold_walk_end", 32'(s0), 3);
    ped0 = 1'b0;
    run(1);
    chk("hold_after", 32'(s0), 2);
    chk("hold_ped0", 32'(p0), 0);
    run(2);
    chk("hold_next", 32'(s0), 0);
    chk("hold_dir", 32'(d0), 2);

    ped0 = 1'b1;
    run(2);
    chk("pre_rst_ped", 32'(p0), 1);
    rst0 = 1'b1;
    ped0 = 1'b0;
    run(1);
    rst0 = 1'b0;
    chk("rg_state", 32'(s0), 2);
    chk("rg_light", 32'(l0), 32'(L0_R));
    chk("rg_walk", 32'(w0), 0);
    chk("rg_ped", 32'(p0), 0);
    chk("rg_dir", 32'(d0), 2);
    run(2);
    chk("rg_green", 32'(l0), 32'(L0_G0));
    ped0 = 1'b1;
    run(1);
    ped0 = 1'b0;
    run(12);
    chk("rw_walk", 32'(s0), 3);
    run(2);
    rst0 = 1'b1;
    run(1);
    rst0 = 1'b0;
    chk("rw_state", 32'(s0), 2);
    chk("rw_walk0", 32'(w0), 0);
    chk("rw_light", 32'(l0), 32'(L0_R));
    chk("rw_ped", 32'(p0), 0);
    chk("rw_dir", 32'(d0), 2);
    run(1);
    chk("rw_c1", 32'(s0), 2);
    run(1);
    chk("rw_c2", 32'(s0), 0);
    chk("rw_c2_dir", 32'(d0), 0);

    rst1 = 1'b0;
    run(10);
    chk("idle_state", 32'(s1), 2);
    chk("idle_light", 32'(l1), 32'(L1_R));
    veh1 = 4'b0010;
    n = 0;
    while (s1 != 2'd0 && n < 4) begin
      run(1);
      n++;
    end
    chk("sense_lat", 32'(n <= 2), 1);
    chk("sense_st", 32'(s1), 0);
    chk("sense_dir", 32'(d1), 1);

    veh1 = 4'b0100;
    n = 0;
    while (!(s1 == 2'd0 && d1 == 2'd2) && n < 20) begin
      run(1);
      n++;
    end
    chk("to_dir2", 32'(s1 == 2'd0 && d1 == 2'd2), 1);
    saw = 1'b0;
    for (int i = 0; i < 24; i++) begin
      run(1);
      if (s1 != 2'd0) saw = 1'b1;
    end
    chk("rest_green", 32'(saw), 0);
    chk("rest_dir", 32'(d1), 2);
    chk("rest_light", 32'(l1), 32'(L1_G2));

    veh1 = 4'b1001;
    saw = 1'b0;
    bad = 1'b0;
    n = 0;
    while (!(s1 == 2'd0 && d1 == 2'd3) && n < 20) begin
      run(1);
      n++;
      if (s1 == 2'd1) saw = 1'b1;
      if (s1 == 2'd0 && (d1 == 2'd1 || d1 == 2'd2) && n > 0)
        bad = (d1 != 2'd2) || saw;
    end
    chk("to_dir3", 32'(s1 == 2'd0 && d1 == 2'd3), 1);
    chk("yel_before3", 32'(saw), 1);
    n = 0;
    while (!(s1 == 2'd0 && d1 == 2'd0) && n < 20) begin
      run(1);
      n++;
      if (s1 == 2'd0 && (d1 == 2'd1 || d1 == 2'd2))
        bad = 1'b1;
    end
    chk("to_dir0", 32'(s1 == 2'd0 && d1 == 2'd0), 1);
    chk("skip_12", 32'(bad), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
